iiitb_scan_mux: RTL and testbench

Registered, parametrised N-channel, W-bit multiplexer. It is the sequential successor of the 4:1 combinational select block. It supports two modes:
- Manual: an externally supplied select picks the channel.
- Scan: an internal round-robin scanner visits enabled channels, spending a fixed dwell period on each.

The output is a registered sample tagged with its channel index, delivered over a valid/ready handshake. It sits between raw channel sources and a downstream sampler or logger.

---
 rtl/iiitb_scan_mux.sv | 158 +++++++++++++++
 tb/tb_iiitb_scan_mux.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iiitb_scan_mux.sv
// Registered N-channel mux with manual select and round-robin scan modes.
// Output is a channel-tagged sample held under a valid/ready handshake.
module iiitb_scan_mux #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned DWELL = 4,
  localparam int unsigned SELW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic                 en,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH-1:0]       ch_mask,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     dout,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  output logic                 sel_err
);

  localparam int unsigned CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);

  logic [WIDTH-1:0] r_dout;
  logic [SELW-1:0]  r_ch;
  logic             r_valid;
  logic             r_err;
  logic [SELW-1:0]  r_ptr;
  logic [CNTW-1:0]  r_cnt;
  logic             r_mode_q;
  logic             r_mode_vld;

  logic [WIDTH-1:0] w_man_data;
  logic [WIDTH-1:0] w_scan_data;
  logic             w_ptr_en;
  logic             w_hi_found;
  logic [SELW-1:0]  w_hi_idx;
  logic [SELW-1:0]  w_lo_idx;
  logic [SELW-1:0]  w_ptr_adv;
  logic             w_free;
  logic             w_sel_ok;
  logic             w_mode_chg;
  logic             w_cap;
  logic [WIDTH-1:0] w_cap_data;
  logic [SELW-1:0]  w_cap_ch;
  logic [WIDTH-1:0] w_dout_nxt;
  logic [SELW-1:0]  w_ch_nxt;
  logic             w_valid_nxt;
  logic             w_err_nxt;
  logic [SELW-1:0]  w_ptr_nxt;
  logic [CNTW-1:0]  w_cnt_nxt;

  assign w_free   = !r_valid || out_ready;
  // Extra bit so the check is meaningful when NCH is a power of two
  assign w_sel_ok = {1'b0, sel} < (SELW+1)'(NCH);
  // No previous mode exists right after reset, so the first cycle never counts as a change
  assign w_mode_chg = r_mode_vld && (mode != r_mode_q);

  // Channel data for the manual select and the scan pointer
  always_comb begin
    w_man_data  = '0;
    w_scan_data = '0;
    w_ptr_en    = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (SELW'(k) == sel) w_man_data = din[k*WIDTH +: WIDTH];
      if (SELW'(k) == r_ptr) begin
        w_scan_data = din[k*WIDTH +: WIDTH];
        w_ptr_en    = ch_mask[k];
      end
    end
  end

  // Next enabled channel after r_ptr, wrapping to the lowest enabled one
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (ch_mask[k]) begin
        w_lo_idx = SELW'(k);
        if (SELW'(k) > r_ptr) begin
          w_hi_found = 1'b1;
          w_hi_idx   = SELW'(k);
        end
      end
    end
    if (w_hi_found)    w_ptr_adv = w_hi_idx;
    else if (|ch_mask) w_ptr_adv = w_lo_idx;
    else               w_ptr_adv = r_ptr;
  end

  always_comb begin
    w_dout_nxt  = r_dout;
    w_ch_nxt    = r_ch;
    w_valid_nxt = r_valid && !out_ready;
    w_err_nxt   = 1'b0;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_cap       = 1'b0;
    w_cap_data  = w_man_data;
    w_cap_ch    = sel;
    if (en) begin
      if (!mode) begin
        if (w_free) begin
          if (w_sel_ok) w_cap     = 1'b1;
          else          w_err_nxt = 1'b1;
        end
      end else if (r_cnt != CNT_LAST) begin
        w_cnt_nxt = r_cnt + CNTW'(1);
      end else if (!w_ptr_en) begin
        w_cnt_nxt = '0;
        w_ptr_nxt = w_ptr_adv;
      end else if (w_free) begin
        w_cap      = 1'b1;
        w_cap_data = w_scan_data;
        w_cap_ch   = r_ptr;
        w_cnt_nxt  = '0;
        w_ptr_nxt  = w_ptr_adv;
      end
    end
    if (w_mode_chg) w_cnt_nxt = '0;
    if (w_cap) begin
      w_dout_nxt  = w_cap_data;
      w_ch_nxt    = w_cap_ch;
      w_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout     <= '0;
      r_ch       <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_mode_q   <= 1'b0;
      r_mode_vld <= 1'b0;
    end else begin
      r_dout     <= w_dout_nxt;
      r_ch       <= w_ch_nxt;
      r_valid    <= w_valid_nxt;
      r_err      <= w_err_nxt;
      r_ptr      <= w_ptr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_mode_q   <= mode;
      r_mode_vld <= 1'b1;
    end
  end

  assign dout      = r_dout;
  assign out_ch    = r_ch;
  assign out_valid = r_valid;
  assign sel_err   = r_err;

endmodule

// File: tb/tb_iiitb_scan_mux.sv
// Bench for iiitb_scan_mux: reference model for a 4-channel instance plus
// directed literal checks, and a 3-channel instance for invalid selects.
module tb_iiitb_scan_mux;

  localparam int NCH   = 4;
  localparam int DWELL = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] din;
  logic        en;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  ch_mask;
  logic        out_ready;
  logic [7:0]  dout;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        sel_err;

  logic [23:0] d3_din;
  logic        d3_en;
  logic [1:0]  d3_sel;
  logic        d3_ready;
  logic [7:0]  d3_dout;
  logic [1:0]  d3_ch;
  logic        d3_valid;
  logic        d3_err;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  logic [7:0] scan_tab [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
  logic [3:0] mtab     [5] = '{4'hF, 4'h5, 4'h8, 4'h0, 4'h6};

  typedef struct packed {
    logic [2:0] cnt;
    logic [1:0] ptr;
    logic [1:0] ch;
    logic [7:0] dout;
    logic       valid;
    logic       err;
    logic       prev;
    logic       known;
  } mstate_t;

  mstate_t m;

  iiitb_scan_mux #(.WIDTH(8), .NCH(4), .DWELL(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en), .mode(mode), .sel(sel),
    .ch_mask(ch_mask), .out_ready(out_ready), .dout(dout), .out_ch(out_ch),
    .out_valid(out_valid), .sel_err(sel_err)
  );

  iiitb_scan_mux #(.WIDTH(8), .NCH(3), .DWELL(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .din(d3_din), .en(d3_en), .mode(1'b0), .sel(d3_sel),
    .ch_mask(3'b111), .out_ready(d3_ready), .dout(d3_dout), .out_ch(d3_ch),
    .out_valid(d3_valid), .sel_err(d3_err)
  );

  always #5 clk = ~clk;

  // First enabled channel found walking forward from p (p itself last)
  function automatic int next_ch(int p, logic [3:0] msk);
    for (int s = 1; s <= NCH; s++)
      if (msk[(p + s) % NCH]) return (p + s) % NCH;
    return p;
  endfunction

  // One clock of the reference behaviour, using the inputs present at the edge
  function automatic mstate_t model_next(mstate_t s);
    mstate_t n = s;
    int      ch = -1;
    bit      free = !s.valid || out_ready;
    n.err = 1'b0;
    if (en) begin
      if (!mode) begin
        if (free) begin
          if (int'(sel) < NCH) ch = int'(sel);
          else n.err = 1'b1;
        end
      end else if (int'(s.cnt) < DWELL - 1) begin
        n.cnt = 3'(int'(s.cnt) + 1);
      end else if (!ch_mask[s.ptr]) begin
        n.cnt = 3'd0;
        n.ptr = 2'(next_ch(int'(s.ptr), ch_mask));
      end else if (free) begin
        ch    = int'(s.ptr);
        n.cnt = 3'd0;
        n.ptr = 2'(next_ch(int'(s.ptr), ch_mask));
      end
    end
    if (s.known && (mode != s.prev)) n.cnt = 3'd0;
    if (ch >= 0) begin
      n.dout  = 8'(din >> (8 * ch));
      n.ch    = 2'(ch);
      n.valid = 1'b1;
    end else if (out_ready) begin
      n.valid = 1'b0;
    end
    n.prev  = mode;
    n.known = 1'b1;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= model_next(m);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] c);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    if (v) begin
      chk({tag, "_dout"}, 32'(dout), 32'(d));
      chk({tag, "_ch"}, 32'(out_ch), 32'(c));
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Model comparison on every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_dout", 32'(dout), 32'(m.dout));
      chk("model_ch", 32'(out_ch), 32'(m.ch));
      chk("model_valid", 32'(out_valid), 32'(m.valid));
      chk("model_err", 32'(sel_err), 32'(m.err));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; din = 32'hDDCCBBAA; en = 1'b1; mode = 1'b1; sel = 2'd0;
    ch_mask = 4'hF; out_ready = 1'b1;
    d3_din = 24'hCCBBAA; d3_en = 1'b0; d3_sel = 2'd0; d3_ready = 1'b1;
    tick(); tick();
    chk_on = 1'b1;
    chk("reset_dout", 32'(dout), 32'h0);
    chk("reset_ch", 32'(out_ch), 32'h0);
    chk("reset_valid", 32'(out_valid), 32'h0);
    chk("reset_err", 32'(sel_err), 32'h0);

    // Full-mask scan: one sample every DWELL edges
    rst_n = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (t % 4 == 0) expect_out("scan_full", 1'b1, scan_tab[(t/4 - 1) % 4], 2'((t/4 - 1) % 4));
      else chk("scan_gap", 32'(out_valid), 32'h0);
    end

    // Asynchronous reset mid-cycle with a sample pending
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dout", 32'(dout), 32'h0);
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_ch", 32'(out_ch), 32'h0);
    tick();

    // Manual select and backpressure
    mode = 1'b0; sel = 2'd2; rst_n = 1'b1;
    tick(); expect_out("man_cc", 1'b1, 8'hCC, 2'd2);
    tick(); expect_out("man_hold", 1'b1, 8'hCC, 2'd2);
    out_ready = 1'b0; sel = 2'd1;
    repeat (5) begin
      tick(); expect_out("bp_hold", 1'b1, 8'hCC, 2'd2);
    end
    out_ready = 1'b1;
    tick(); expect_out("bp_release", 1'b1, 8'hBB, 2'd1);

    // Sparse mask with a stall at the DD terminal
    rst_n = 1'b0; mode = 1'b1; ch_mask = 4'b1010;
    tick();
    rst_n = 1'b1;
    for (int t = 1; t <= 18; t++) begin
      tick();
      if (t == 8 || t == 18)       expect_out("sparse_bb", 1'b1, 8'hBB, 2'd1);
      else if (t >= 9 && t <= 13)  expect_out("stall_hold", 1'b1, 8'hBB, 2'd1);
      else if (t == 14)            expect_out("sparse_dd", 1'b1, 8'hDD, 2'd3);
      else                         chk("sparse_gap", 32'(out_valid), 32'h0);
      if (t == 8)  out_ready = 1'b0;
      if (t == 13) out_ready = 1'b1;
    end

    // Enable low freezes the scanner; DD follows DWELL edges after re-enable
    en = 1'b0;
    repeat (6) begin
      tick(); chk("en_off", 32'(out_valid), 32'h0);
    end
    en = 1'b1;
    repeat (3) begin
      tick(); chk("en_resume_gap", 32'(out_valid), 32'h0);
    end
    tick(); expect_out("en_resume_dd", 1'b1, 8'hDD, 2'd3);

    // Mixed traffic: mode flips, masks, stalls and gaps, checked by the model
    for (int i = 0; i < 80; i++) begin
      mode      = 1'((i % 29) < 15);
      en        = 1'((i % 11) != 0);
      sel       = 2'(i);
      out_ready = 1'((i % 5 != 2) && (i % 7 != 3));
      ch_mask   = mtab[i / 16];
      din       = 32'hDDCCBBAA ^ (32'(i) * 32'h01030507);
      tick();
    end

    // Three-channel instance: select 3 is out of range
    d3_en = 1'b1; d3_sel = 2'd3;
    tick();
    chk("d3_err_first", 32'(d3_err), 32'h1);
    chk("d3_err_novalid", 32'(d3_valid), 32'h0);
    chk("d3_err_dout", 32'(d3_dout), 32'h0);
    d3_sel = 2'd1;
    tick();
    chk("d3_err_clear", 32'(d3_err), 32'h0);
    chk("d3_cap_valid", 32'(d3_valid), 32'h1);
    chk("d3_cap_dout", 32'(d3_dout), 32'hBB);
    chk("d3_cap_ch", 32'(d3_ch), 32'h1);
    d3_sel = 2'd3;
    tick();
    chk("d3_err_again", 32'(d3_err), 32'h1);
    chk("d3_consumed", 32'(d3_valid), 32'h0);
    chk("d3_dout_hold", 32'(d3_dout), 32'hBB);
    d3_ready = 1'b0; d3_sel = 2'd2;
    tick();
    chk("d3_cc_valid", 32'(d3_valid), 32'h1);
    chk("d3_cc_dout", 32'(d3_dout), 32'hCC);
    chk("d3_cc_err", 32'(d3_err), 32'h0);
    d3_sel = 2'd3;
    tick();
    chk("d3_blocked_err", 32'(d3_err), 32'h0);
    chk("d3_blocked_valid", 32'(d3_valid), 32'h1);
    chk("d3_blocked_dout", 32'(d3_dout), 32'hCC);
    d3_en = 1'b0;
    tick();

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
